// File: rtl/tilt_direction_decoder.sv
// Per-axis tilt decoder: block-averages accelerometer samples, classifies them against a
// deadband with hysteresis, and debounces over HOLD_SAMPLES averages before committing a direction.
module tilt_direction_decoder #(
  parameter int WIDTH        = 9,
  parameter int CENTER_X     = 385,
  parameter int CENTER_Y     = 80,
  parameter int DEADBAND     = 8,
  parameter int HYST         = 4,
  parameter int AVG_LOG2     = 2,
  parameter int HOLD_SAMPLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] accel_x,
  input  logic [WIDTH-1:0] accel_y,
  output logic             up,
  output logic             down,
  output logic             right,
  output logic             left,
  output logic             restx,
  output logic             resty,
  output logic             avg_strobe,
  output logic             changed
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int D_W   = WIDTH + 2;
  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);

  localparam logic signed [D_W-1:0] DB_HI  = D_W'(DEADBAND);
  localparam logic signed [D_W-1:0] DB_LO  = -D_W'(DEADBAND);
  localparam logic signed [D_W-1:0] REL_HI = D_W'(DEADBAND - HYST);
  localparam logic signed [D_W-1:0] REL_LO = -D_W'(DEADBAND - HYST);

  typedef enum logic [1:0] {ST_REST = 2'd0, ST_POS = 2'd1, ST_NEG = 2'd2} dir_e;

  typedef struct packed {
    dir_e             com;
    dir_e             pend;
    logic [CNT_W-1:0] cnt;
  } deb_t;

  function automatic logic signed [D_W-1:0] offset(input logic [WIDTH-1:0] avg,
                                                   input int center);
    logic signed [D_W-1:0] a;
    logic signed [D_W-1:0] c;
    a = $signed({2'b00, avg});
    c = D_W'(center);
    offset = a - c;
  endfunction

  // Hysteresis: leaving a committed direction needs the average to fall well inside the deadband.
  function automatic dir_e classify(input dir_e com, input logic signed [D_W-1:0] d);
    classify = ST_REST;
    case (com)
      ST_POS: begin
        if (d < DB_LO)        classify = ST_NEG;
        else if (d <= REL_HI) classify = ST_REST;
        else                  classify = ST_POS;
      end
      ST_NEG: begin
        if (d > DB_HI)        classify = ST_POS;
        else if (d >= REL_LO) classify = ST_REST;
        else                  classify = ST_NEG;
      end
      default: begin
        if (d > DB_HI)        classify = ST_POS;
        else if (d < DB_LO)   classify = ST_NEG;
        else                  classify = ST_REST;
      end
    endcase
  endfunction

  function automatic deb_t debounce(input deb_t cur, input dir_e cand);
    deb_t             nxt;
    logic [CNT_W-1:0] ncnt;
    nxt  = cur;
    ncnt = '0;
    if (cand == cur.com) begin
      nxt.pend = cur.com;
      nxt.cnt  = '0;
    end else begin
      if (cand == cur.pend) begin
        ncnt = cur.cnt + CNT_W'(1);
      end else begin
        nxt.pend = cand;
        ncnt     = CNT_W'(1);
      end
      if (ncnt == CNT_W'(HOLD_SAMPLES)) begin
        nxt.com = nxt.pend;
        nxt.cnt = '0;
      end else begin
        nxt.cnt = ncnt;
      end
    end
    return nxt;
  endfunction

  // Stage p0: block accumulation
  logic [ACC_W-1:0]    acc_x_p0, acc_y_p0;
  logic [AVG_LOG2-1:0] blk_cnt_p0;
  logic [ACC_W-1:0]    sum_x, sum_y;
  logic                blk_last;

  assign sum_x    = acc_x_p0 + ACC_W'(accel_x);
  assign sum_y    = acc_y_p0 + ACC_W'(accel_y);
  assign blk_last = sample_valid && (&blk_cnt_p0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_x_p0   <= '0;
      acc_y_p0   <= '0;
      blk_cnt_p0 <= '0;
    end else if (sample_valid) begin
      blk_cnt_p0 <= blk_cnt_p0 + AVG_LOG2'(1);
      acc_x_p0   <= blk_last ? '0 : sum_x;
      acc_y_p0   <= blk_last ? '0 : sum_y;
    end
  end

  // Stage p1: registered block averages
  logic [WIDTH-1:0] avg_x_p1, avg_y_p1;
  logic             vld_p1;

  always_ff @(posedge clock) begin
    if (blk_last) begin
      avg_x_p1 <= WIDTH'(sum_x >> AVG_LOG2);
      avg_y_p1 <= WIDTH'(sum_y >> AVG_LOG2);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= blk_last;
  end

  // Stage p2: classification, debounce and committed direction
  deb_t deb_x_p2, deb_y_p2;
  deb_t nxt_x, nxt_y;
  logic chg_p2;

  always_comb begin
    nxt_x = deb_x_p2;
    nxt_y = deb_y_p2;
    if (vld_p1) begin
      nxt_x = debounce(deb_x_p2, classify(deb_x_p2.com, offset(avg_x_p1, CENTER_X)));
      nxt_y = debounce(deb_y_p2, classify(deb_y_p2.com, offset(avg_y_p1, CENTER_Y)));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_x_p2 <= '{com: ST_REST, pend: ST_REST, cnt: '0};
      deb_y_p2 <= '{com: ST_REST, pend: ST_REST, cnt: '0};
      chg_p2   <= 1'b0;
    end else begin
      deb_x_p2 <= nxt_x;
      deb_y_p2 <= nxt_y;
      chg_p2   <= (nxt_x.com != deb_x_p2.com) || (nxt_y.com != deb_y_p2.com);
    end
  end

  assign up         = (deb_x_p2.com == ST_POS);
  assign down       = (deb_x_p2.com == ST_NEG);
  assign restx      = (deb_x_p2.com == ST_REST);
  assign right      = (deb_y_p2.com == ST_POS);
  assign left       = (deb_y_p2.com == ST_NEG);
  assign resty      = (deb_y_p2.com == ST_REST);
  assign avg_strobe = vld_p1;
  assign changed    = chg_p2;

endmodule

// File: tb/tb_tilt_direction_decoder.sv
// Scoreboard bench for tilt_direction_decoder: a behavioural model predicts committed
// directions per completed block; the monitor compares them after each avg_strobe.
module tb_tilt_direction_decoder;

  localparam int CX = 385, CY = 80, DB = 8, HY = 4, HOLD = 3, BLK = 4;
  localparam int D_REST = 0, D_POS = 1, D_NEG = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [8:0] accel_x = '0;
  logic [8:0] accel_y = '0;
  logic       up, down, right, left, restx, resty, avg_strobe, changed;

  always #5 clock = ~clock;

  tilt_direction_decoder dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .accel_x(accel_x), .accel_y(accel_y),
    .up(up), .down(down), .right(right), .left(left),
    .restx(restx), .resty(resty), .avg_strobe(avg_strobe), .changed(changed)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int    x_dir;
    int    y_dir;
    int    chg;
    string tag;
  } exp_t;
  exp_t sb[$];

  int acc_x, acc_y, n_smp;
  int com_x, pend_x, cnt_x;
  int com_y, pend_y, cnt_y;

  function automatic int cls(input int com, input int d);
    if (com == D_POS)      return (d < -DB) ? D_NEG : (d <= DB - HY)    ? D_REST : D_POS;
    else if (com == D_NEG) return (d > DB)  ? D_POS : (d >= -(DB - HY)) ? D_REST : D_NEG;
    else                   return (d > DB)  ? D_POS : (d < -DB)         ? D_NEG  : D_REST;
  endfunction

  task automatic deb(input int cand, inout int com, inout int pend, inout int cnt);
    if (cand == com) begin
      pend = com;
      cnt  = 0;
    end else begin
      if (cand == pend) cnt++;
      else begin
        pend = cand;
        cnt  = 1;
      end
      if (cnt == HOLD) begin
        com = pend;
        cnt = 0;
      end
    end
  endtask

  task automatic model_clear();
    acc_x = 0; acc_y = 0; n_smp = 0;
    com_x = D_REST; pend_x = D_REST; cnt_x = 0;
    com_y = D_REST; pend_y = D_REST; cnt_y = 0;
  endtask

  string cur_tag = "init";

  task automatic send(input int x, input int y, input int gap = 0);
    int   ox, oy;
    exp_t e;
    repeat (gap) @(posedge clock);
    @(negedge clock);
    sample_valid = 1'b1;
    accel_x = 9'(x);
    accel_y = 9'(y);
    @(posedge clock);
    acc_x += x; acc_y += y; n_smp++;
    if (n_smp == BLK) begin
      ox = com_x; oy = com_y;
      deb(cls(com_x, (acc_x / BLK) - CX), com_x, pend_x, cnt_x);
      deb(cls(com_y, (acc_y / BLK) - CY), com_y, pend_y, cnt_y);
      e.x_dir = com_x; e.y_dir = com_y;
      e.chg = (ox != com_x || oy != com_y) ? 1 : 0;
      e.tag = cur_tag;
      sb.push_back(e);
      acc_x = 0; acc_y = 0; n_smp = 0;
    end
    #1 sample_valid = 1'b0;
  endtask

  task automatic send_n(input int cnt, input int x, input int y);
    for (int i = 0; i < cnt; i++) send(x, y);
  endtask

  function automatic logic [2:0] onehot(input int d);
    return (d == D_POS) ? 3'b100 : (d == D_NEG) ? 3'b010 : 3'b001;
  endfunction

  // Monitor: strobe seen at one negedge, committed result sampled at the next.
  bit chk_pend = 0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) chk_pend = 0;
    else begin
      if (chk_pend && sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_x"}, {up, down, restx}, onehot(e.x_dir));
        check({e.tag, "_y"}, {right, left, resty}, onehot(e.y_dir));
        check({e.tag, "_chg"}, changed, e.chg);
      end else if (!chk_pend) begin
        check({cur_tag, "_idle_chg"}, changed, 0);
      end
      if (avg_strobe) check({cur_tag, "_strobe_expected"}, sb.size() > 0, 1);
      chk_pend = avg_strobe;
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check({tag, "_rst_x"}, {up, down, restx}, 3'b001);
    check({tag, "_rst_y"}, {right, left, resty}, 3'b001);
    check({tag, "_rst_strb_chg"}, {avg_strobe, changed}, 2'b00);
    sb.delete();
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(negedge clock);
  endtask

  initial begin
    model_clear();
    do_reset("por");

    cur_tag = "t2_commit";
    send_n(12, 400, 80);
    idle(3);
    check("t2_up_final", up, 1);

    cur_tag = "t1_midrun";
    send_n(6, 400, 80);
    idle(3);
    do_reset("t1");
    cur_tag = "t1_after";
    send_n(3, 385, 80);
    idle(3);
    send(385, 80);
    idle(3);

    cur_tag = "t3_db_edge";
    send_n(12, 393, 80);
    cur_tag = "t3_db_out";
    send_n(12, 394, 80);
    idle(3);
    check("t3_up_final", up, 1);

    cur_tag = "t4_hold_pos";
    send_n(12, 390, 80);
    cur_tag = "t4_release";
    send_n(12, 389, 80);
    cur_tag = "t4_up_again";
    send_n(12, 400, 80);
    cur_tag = "t4_reverse";
    send_n(12, 370, 80);
    idle(3);
    check("t4_down_final", down, 1);

    cur_tag = "t5_glitch";
    for (int b = 0; b < 3; b++) begin
      send(385, 60); send(385, 100); send(385, 60); send(385, 100);
    end
    cur_tag = "t5_left";
    send_n(12, 385, 70);
    cur_tag = "t5_restart";
    send_n(8, 400, 70);
    send_n(4, 385, 70);
    send_n(8, 400, 70);
    idle(3);
    check("t5_no_commit", restx, 1);
    send_n(4, 400, 70);
    idle(3);
    check("t5_up_final", up, 1);

    cur_tag = "t6_partial";
    send_n(2, 511, 511);
    idle(2);
    do_reset("t6");
    cur_tag = "t6_gaps";
    send(400, 80, 2); send(400, 80, 1); send(400, 80, 3); send(400, 80, 2);
    send_n(8, 400, 80);
    idle(3);
    check("t6_up_final", up, 1);

    idle(4);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
